accel_spi_sequencer: RTL and testbench

//  Sequences the byte-level SPI master for the 3-axis accelerometer. After reset it runs bring-up:
//  - reads and checks the device ID;
//  - writes POWER_CTL to enter measurement mode.
//  It then reads the six X/Y/Z data bytes every SAMPLE_CYC clocks and publishes them as a sample.
//  It sits between the SPI master and the sample FIFO/display logic, and is the only requester of the SPI master.

---
 rtl/accel_spi_sequencer.sv | 128 ++++++++++++
 tb/tb_accel_spi_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/accel_spi_sequencer.sv
// accel_spi_sequencer: boots the accelerometer (ID check, POWER_CTL write), then reads X/Y/Z
// through the byte-level SPI master every SAMPLE_CYC clocks and publishes signed 12-bit samples.
module accel_spi_sequencer #(
  parameter int         SAMPLE_CYC  = 100000,
  parameter int         TIMEOUT_CYC = 8192,
  parameter logic [7:0] EXP_ID      = 8'hAD,
  parameter logic [7:0] PWR_VAL     = 8'h02
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_enable,
  output logic               o_spi_req,
  output logic [3:0]         o_spi_n_wr,
  output logic [3:0]         o_spi_n_rd,
  output logic [7:0]         o_spi_tx_byte,
  input  logic               i_spi_tx_ack,
  input  logic               i_spi_rx_valid,
  input  logic [7:0]         i_spi_rx_byte,
  input  logic               i_spi_busy,
  output logic signed [11:0] o_x_out,
  output logic signed [11:0] o_y_out,
  output logic signed [11:0] o_z_out,
  output logic               o_sample_valid,
  output logic               o_id_ok,
  output logic               o_err
);
  localparam int TW = $clog2(SAMPLE_CYC);
  localparam int OW = $clog2(TIMEOUT_CYC);
  typedef enum logic [2:0] {BOOT, ID_RD, ID_CHK, PWR_WR, IDLE, DATA_RD, PUBLISH, ERR} state_t;
  state_t        r_state, w_next;
  logic [3:0]    r_boot_cnt;
  logic [1:0]    r_tx_idx;
  logic [2:0]    r_rx_idx;
  logic [7:0]    r_rx [6];
  logic [OW-1:0] r_tmo;
  logic [TW-1:0] r_tmr;
  logic          r_tmr_run, r_pend, r_busy_d;
  logic          w_txn, w_done, w_tmo, w_load, w_wrap;
  // MOSI byte i of the transaction issued from state s
  function automatic logic [7:0] txb(state_t s, logic [1:0] i);
    return i == 2'd0 ? (s == PWR_WR ? 8'h0A : 8'h0B) :
           i == 2'd1 ? (s == ID_RD ? 8'h00 : s == PWR_WR ? 8'h2D : 8'h0E) : PWR_VAL;
  endfunction
  assign w_txn  = r_state inside {ID_RD, PWR_WR, DATA_RD};
  assign w_done = w_txn && r_busy_d && !i_spi_busy;
  assign w_tmo  = w_txn && r_tmo == OW'(TIMEOUT_CYC - 1);
  assign w_load = w_next != r_state && w_next inside {ID_RD, PWR_WR, DATA_RD};
  assign w_wrap = r_tmr_run && r_tmr == TW'(SAMPLE_CYC - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= BOOT;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      BOOT:    w_next = r_boot_cnt == 4'd15 ? ID_RD : BOOT;
      ID_RD:   w_next = w_tmo ? ERR : w_done ? ID_CHK : ID_RD;
      ID_CHK:  w_next = r_rx[0] == EXP_ID ? PWR_WR : ERR;
      PWR_WR:  w_next = w_tmo ? ERR : w_done ? IDLE : PWR_WR;
      IDLE:    w_next = r_pend && i_enable ? DATA_RD : IDLE;
      DATA_RD: w_next = w_tmo ? ERR : !w_done ? DATA_RD : r_rx_idx == 3'd6 ? PUBLISH : IDLE;
      PUBLISH: w_next = IDLE;
      default: w_next = ERR;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_spi_req      <= 1'b0;
      o_spi_n_wr     <= '0;
      o_spi_n_rd     <= '0;
      o_spi_tx_byte  <= '0;
      o_x_out        <= '0;
      o_y_out        <= '0;
      o_z_out        <= '0;
      o_sample_valid <= 1'b0;
      o_id_ok        <= 1'b0;
      o_err          <= 1'b0;
      r_boot_cnt     <= '0;
      r_tx_idx       <= '0;
      r_rx_idx       <= '0;
      r_rx           <= '{default: '0};
      r_tmo          <= '0;
      r_tmr          <= '0;
      r_tmr_run      <= 1'b0;
      r_pend         <= 1'b0;
      r_busy_d       <= 1'b0;
    end else begin
      r_busy_d       <= i_spi_busy;
      o_sample_valid <= w_next == PUBLISH;
      if (r_state == BOOT) r_boot_cnt <= r_boot_cnt + 4'd1;
      if (w_load) begin
        o_spi_req     <= 1'b1;
        o_spi_n_wr    <= w_next == PWR_WR ? 4'd3 : 4'd2;
        o_spi_n_rd    <= w_next == ID_RD ? 4'd1 : w_next == DATA_RD ? 4'd6 : 4'd0;
        o_spi_tx_byte <= txb(w_next, 2'd0);
        r_tx_idx      <= '0;
        r_rx_idx      <= '0;
        r_tmo         <= '0;
      end else if (w_txn) begin
        r_tmo <= r_tmo + OW'(1);
        if (i_spi_busy) o_spi_req <= 1'b0;
        if (i_spi_tx_ack && {2'b0, r_tx_idx} + 4'd1 < o_spi_n_wr) begin
          r_tx_idx      <= r_tx_idx + 2'd1;
          o_spi_tx_byte <= txb(r_state, r_tx_idx + 2'd1);
        end
        if (i_spi_rx_valid && {1'b0, r_rx_idx} < o_spi_n_rd) begin
          r_rx[r_rx_idx] <= i_spi_rx_byte;
          r_rx_idx       <= r_rx_idx + 3'd1;
        end
      end
      if (w_next == ERR) begin
        o_spi_req <= 1'b0;
        o_err     <= 1'b1;
      end
      if (r_state == ID_CHK) o_id_ok <= r_rx[0] == EXP_ID;
      if (w_next == PUBLISH) begin
        o_x_out <= {r_rx[1][3:0], r_rx[0]};
        o_y_out <= {r_rx[3][3:0], r_rx[2]};
        o_z_out <= {r_rx[5][3:0], r_rx[4]};
      end
      // sample timer starts once measurement mode is written; at most one wrap is remembered
      if (r_state == PWR_WR && w_done) begin
        r_tmr     <= '0;
        r_tmr_run <= 1'b1;
      end else if (r_tmr_run) r_tmr <= w_wrap ? '0 : r_tmr + TW'(1);
      r_pend <= w_wrap || (r_pend && !(w_load && w_next == DATA_RD));
    end
  end
endmodule

// File: tb/tb_accel_spi_sequencer.sv
// tb_accel_spi_sequencer: SPI master/slave model plus scoreboards for MOSI bytes and published samples.
module tb_accel_spi_sequencer;
  localparam int SC = 200;
  localparam int TMO = 1000;
  logic clk = 0, rst_n = 1, i_enable = 0;
  logic o_spi_req, i_spi_tx_ack, i_spi_rx_valid, i_spi_busy;
  logic [3:0] o_spi_n_wr, o_spi_n_rd;
  logic [7:0] o_spi_tx_byte, i_spi_rx_byte;
  logic signed [11:0] o_x_out, o_y_out, o_z_out;
  logic o_sample_valid, o_id_ok, o_err;
  int n_cmp = 0, n_bad = 0, cyc = 0, req_cnt = 0;
  logic req_prev = 0;
  logic [7:0] rx_tbl [6];
  logic [7:0] mq [$];
  logic [35:0] sq [$];
  bit m_hang = 0, ab = 0;

  accel_spi_sequencer #(.SAMPLE_CYC(SC), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable),
    .o_spi_req(o_spi_req), .o_spi_n_wr(o_spi_n_wr), .o_spi_n_rd(o_spi_n_rd),
    .o_spi_tx_byte(o_spi_tx_byte), .i_spi_tx_ack(i_spi_tx_ack), .i_spi_rx_valid(i_spi_rx_valid),
    .i_spi_rx_byte(i_spi_rx_byte), .i_spi_busy(i_spi_busy),
    .o_x_out(o_x_out), .o_y_out(o_y_out), .o_z_out(o_z_out),
    .o_sample_valid(o_sample_valid), .o_id_ok(o_id_ok), .o_err(o_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    req_cnt  <= req_cnt + int'(o_spi_req && !req_prev);
    req_prev <= o_spi_req;
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // sample scoreboard: every pulse must match the oldest expected sample
  always @(negedge clk)
    if (o_sample_valid) begin
      if (sq.size() > 0) chk("sample_xyz", {o_x_out, o_y_out, o_z_out}, sq.pop_front());
      else chk("sample_unexpected", {o_x_out, o_y_out, o_z_out}, 36'hx);
    end

  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst_n) ab = 1;
  endtask

  // SPI master + accelerometer model; MOSI bytes checked against mq while it holds entries
  initial begin : master
    int nw, nr;
    i_spi_busy = 0; i_spi_tx_ack = 0; i_spi_rx_valid = 0; i_spi_rx_byte = 0;
    forever begin
      tick();
      if (o_spi_req && rst_n) begin
        ab = 0; nw = int'(o_spi_n_wr); nr = int'(o_spi_n_rd);
        i_spi_busy = 1; tick(); tick();
        for (int i = 0; i < nw && !ab; i++) begin
          if (mq.size() > 0) chk("mosi_byte", o_spi_tx_byte, mq.pop_front());
          i_spi_tx_ack = 1; tick(); i_spi_tx_ack = 0; tick();
        end
        for (int i = 0; i < nr && i < 6 && !ab; i++) begin
          i_spi_rx_byte = rx_tbl[i]; i_spi_rx_valid = 1; tick(); i_spi_rx_valid = 0; tick();
        end
        while (m_hang && !ab) tick();
        i_spi_busy = 0; i_spi_tx_ack = 0; i_spi_rx_valid = 0;
      end
    end
  end

  function automatic logic sig(int s);
    return s == 0 ? o_sample_valid : s == 1 ? o_err : s == 2 ? o_id_ok : (o_spi_req && o_spi_n_rd == 4'd6);
  endfunction

  task automatic wait_for(string nm, int s, int lim);
    int k = 0;
    do begin @(negedge clk); k++; end while (!sig(s) && k < lim);
    chk(nm, sig(s), 1);
  endtask

  task automatic wait_clks(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : main
    int t0, r;
    rx_tbl = '{8'hAD, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    #2 rst_n = 0;
    wait_clks(3);
    chk("rst_req", o_spi_req, 0);
    chk("rst_nwr", o_spi_n_wr, 0);
    chk("rst_nrd", o_spi_n_rd, 0);
    chk("rst_tx", o_spi_tx_byte, 0);
    chk("rst_xyz", {o_x_out, o_y_out, o_z_out}, 0);
    chk("rst_flags", {o_sample_valid, o_id_ok, o_err}, 0);
    // boot with matching ID
    mq = {8'h0B, 8'h00, 8'h0A, 8'h2D, 8'h02};
    rst_n = 1;
    wait_for("boot_id_ok", 2, 300);
    wait_clks(40);
    chk("boot_mosi_left", mq.size(), 0);
    chk("boot_err", o_err, 0);
    // periodic data reads
    rx_tbl = '{8'h34, 8'hF2, 8'hFF, 8'h0F, 8'h00, 8'h08};
    repeat (3) sq.push_back({12'h234, 12'hFFF, 12'h800});
    mq = {8'h0B, 8'h0E};
    i_enable = 1;
    wait_for("s3_pub1", 0, 400);
    wait_for("s3_pub2", 0, 400);
    t0 = cyc;
    wait_for("s3_pub3", 0, 400);
    i_enable = 0;
    chk("s3_period", cyc - t0, SC);
    chk("s3_mosi_left", mq.size(), 0);
    wait_clks(300);
    chk("s3_sq_left", sq.size(), 0);
    // enable dropped mid read
    rx_tbl = '{8'h01, 8'h00, 8'hFF, 8'h07, 8'h5A, 8'h03};
    sq.push_back({12'h001, 12'h7FF, 12'h35A});
    i_enable = 1;
    wait_for("s5_req", 3, 50);
    wait_clks(3);
    i_enable = 0;
    wait_for("s5_pub", 0, 100);
    r = req_cnt;
    wait_clks(500);
    chk("s5_no_req", req_cnt, r);
    sq.push_back({12'h001, 12'h7FF, 12'h35A});
    i_enable = 1;
    wait_for("s5_pub2", 0, 400);
    i_enable = 0;
    wait_clks(300);
    chk("s5_one_read", req_cnt, r + 1);
    chk("s5_sq_left", sq.size(), 0);
    // slave hangs with busy high
    m_hang = 1;
    i_enable = 1;
    wait_for("s4_req", 3, 400);
    t0 = cyc;
    i_enable = 0;
    wait_for("s4_err", 1, TMO + 50);
    chk("s4_tmo_cycles", cyc - t0, TMO);
    chk("s4_req_low", o_spi_req, 0);
    // recover, then reset mid data read
    m_hang = 0;
    rst_n = 0;
    wait_clks(3);
    rx_tbl[0] = 8'hAD;
    rst_n = 1;
    wait_for("s6_boot1", 2, 300);
    sq.push_back({12'h0AD, 12'h7FF, 12'h35A});
    i_enable = 1;
    wait_for("s6_pub", 0, 400);
    wait_for("s6_req", 3, 400);
    wait_clks(4);
    rst_n = 0;
    #1;
    chk("s6_req_zero", o_spi_req, 0);
    chk("s6_nrd_zero", o_spi_n_rd, 0);
    chk("s6_tx_zero", o_spi_tx_byte, 0);
    chk("s6_xyz_zero", {o_x_out, o_y_out, o_z_out}, 0);
    chk("s6_idok_zero", o_id_ok, 0);
    i_enable = 0;
    wait_clks(3);
    mq = {8'h0B, 8'h00, 8'h0A, 8'h2D, 8'h02};
    rst_n = 1;
    wait_for("s6_reboot", 2, 300);
    wait_clks(40);
    chk("s6_mosi_left", mq.size(), 0);
    chk("s6_err", o_err, 0);
    chk("s6_sq_left", sq.size(), 0);
    // wrong ID
    rst_n = 0;
    wait_clks(3);
    rx_tbl[0] = 8'hE5;
    mq = {8'h0B, 8'h00};
    rst_n = 1;
    wait_for("s2_err", 1, 300);
    chk("s2_id_ok", o_id_ok, 0);
    r = req_cnt;
    wait_clks(10 * SC);
    chk("s2_no_req", req_cnt, r);
    chk("s2_mosi_left", mq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
